// File: rtl/div_result_buffer_pkg.sv
// Types and constants shared between the divider and its result buffer.
package div_result_buffer_pkg;

    // Default operand width of the divider datapath.
    localparam int DATA_W_DEFAULT = 32;

    // The divider drives an all-ones remainder (and quotient) on divide-by-zero.
    localparam logic [DATA_W_DEFAULT-1:0] DZ_PATTERN = {DATA_W_DEFAULT{1'b1}};

    // One buffered divider result at the default width.
    typedef struct packed {
        logic                      dz;
        logic [DATA_W_DEFAULT-1:0] quotient;
        logic [DATA_W_DEFAULT-1:0] remainder;
    } div_entry_t;

    // Divide-by-zero detection at the default width.
    function automatic logic is_dz(input logic [DATA_W_DEFAULT-1:0] remainder);
        return remainder == DZ_PATTERN;
    endfunction

endpackage

// File: rtl/div_result_mem.sv
// Result storage: register array, synchronous write, asynchronous read so the
// head entry can fall through to the outputs without a read cycle.
module div_result_mem #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 65,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the incoming entry into its slot; contents need no reset because
    // validity is tracked entirely by the count register.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/div_result_buffer.sv
// Captures every divider result (which cannot be stalled) into a small circular
// FIFO and re-presents it as a first-word-fall-through ready/valid stream.
module div_result_buffer
    import div_result_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int AF_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [DATA_W-1:0]        i_quotient,
    input  logic [DATA_W-1:0]        i_remainder,
    input  logic                     o_ready,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_quotient,
    output logic [DATA_W-1:0]        o_remainder,
    output logic                     o_div_by_zero,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_almost_full,
    output logic                     o_overflow,
    input  logic                     clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * DATA_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          push;
    logic          pop;
    logic          in_dz;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // A remainder of all ones is only produced by the divide-by-zero convention,
    // since any legal remainder is strictly below the divisor.
    assign in_dz    = (i_remainder == {DATA_W{1'b1}});
    assign wr_entry = {in_dz, i_quotient, i_remainder};

    assign full = (count_q == FULL_CNT);
    assign pop  = o_valid && o_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign push = i_valid && (!full || pop);

    div_result_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .ADDR_W(AW)
    ) u_mem (
        .clk    (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(wr_entry),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_entry)
    );

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A dropped result outranks a clear arriving in the same cycle.
        if (i_valid && !push) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // State registers; reset discards all stored entries by emptying the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Head presentation; data is zeroed whenever nothing is valid.
    always_comb begin
        o_valid       = (count_q != '0);
        o_div_by_zero = 1'b0;
        o_quotient    = '0;
        o_remainder   = '0;
        if (o_valid) begin
            o_div_by_zero = rd_entry[EW-1];
            o_quotient    = rd_entry[EW-2:DATA_W];
            o_remainder   = rd_entry[DATA_W-1:0];
        end
    end

    assign o_count       = count_q;
    assign o_almost_full = (count_q >= AF_CNT);
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_div_result_buffer.sv
// Directed scenarios followed by random traffic, all checked every cycle
// against a queue-based model of the result buffer.
module tb_div_result_buffer;

    localparam int DEPTH     = 4;
    localparam int DATA_W    = 32;
    localparam int AF_MARGIN = 1;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic              clk;
    logic              reset;
    logic              i_valid;
    logic [DATA_W-1:0] i_quotient;
    logic [DATA_W-1:0] i_remainder;
    logic              o_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_quotient;
    logic [DATA_W-1:0] o_remainder;
    logic              o_div_by_zero;
    logic [2:0]        o_count;
    logic              o_almost_full;
    logic              o_overflow;
    logic              clr_overflow;

    div_result_buffer #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_quotient   (i_quotient),
        .i_remainder  (i_remainder),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero),
        .o_count      (o_count),
        .o_almost_full(o_almost_full),
        .o_overflow   (o_overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dz;
        logic [31:0] q;
        logic [31:0] r;
    } entry_t;

    entry_t mdl_q[$];
    logic   mdl_ovf;
    int     errors = 0;
    int     checks = 0;
    int     txn    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model says the buffer holds.
    task automatic check_all(input string tag);
        int n;
        n = mdl_q.size();
        check({tag, ".valid"}, 64'(o_valid), 64'(n != 0));
        check({tag, ".count"}, 64'(o_count), 64'(n));
        check({tag, ".afull"}, 64'(o_almost_full), 64'(n >= DEPTH - AF_MARGIN));
        check({tag, ".ovf"}, 64'(o_overflow), 64'(mdl_ovf));
        if (n != 0) begin
            check({tag, ".q"}, 64'(o_quotient), 64'(mdl_q[0].q));
            check({tag, ".r"}, 64'(o_remainder), 64'(mdl_q[0].r));
            check({tag, ".dz"}, 64'(o_div_by_zero), 64'(mdl_q[0].dz));
        end else begin
            check({tag, ".q0"}, 64'(o_quotient), 64'd0);
            check({tag, ".r0"}, 64'(o_remainder), 64'd0);
            check({tag, ".dz0"}, 64'(o_div_by_zero), 64'd0);
        end
    endtask

    // One clock of traffic: drive, let the edge happen, update model, compare.
    task automatic step(input string tag, input logic v, input logic [31:0] q,
                        input logic [31:0] r, input logic rdy, input logic clr);
        bit     do_pop;
        bit     do_push;
        entry_t e;
        i_valid      = v;
        i_quotient   = q;
        i_remainder  = r;
        o_ready      = rdy;
        clr_overflow = clr;
        do_pop  = (mdl_q.size() != 0) && rdy;
        do_push = v && ((mdl_q.size() < DEPTH) || do_pop);
        @(posedge clk);
        #1;
        if (do_pop) void'(mdl_q.pop_front());
        if (do_push) begin
            e.q = q;
            e.r = r;
            e.dz = (r == ONES);
            mdl_q.push_back(e);
        end
        if (v && !do_push) mdl_ovf = 1'b1;
        else if (clr) mdl_ovf = 1'b0;
        txn++;
        $display("txn %0d %s push=%0b pop=%0b q=%0h count=%0d", txn, tag, do_push, do_pop, q, mdl_q.size());
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic rdy);
        step(tag, 1'b0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        i_valid      = 1'b0;
        i_quotient   = '0;
        i_remainder  = '0;
        o_ready      = 1'b0;
        clr_overflow = 1'b0;
        mdl_ovf      = 1'b0;
        #12;
        check_all("reset");
        reset = 1'b0;

        // Single result, then pop.
        step("t1.push", 1'b1, 32'd3, 32'd2, 1'b0, 1'b0);
        idle("t1.pop", 1'b1);

        // Divide-by-zero tagging.
        step("t2.dz", 1'b1, ONES, ONES, 1'b0, 1'b0);
        step("t2.nodz", 1'b1, ONES, 32'd0, 1'b0, 1'b0);
        idle("t2.pop0", 1'b1);
        idle("t2.pop1", 1'b1);

        // Fill, overflow, drain.
        for (int i = 1; i <= 4; i++) step("t3.fill", 1'b1, 32'(i), 32'd0, 1'b0, 1'b0);
        step("t3.ovf", 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle("t3.drain", 1'b1);
        step("t3.clr", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) step("t4.fill", 1'b1, 32'(i), 32'd1, 1'b0, 1'b0);
        step("t4.pushpop", 1'b1, 32'd9, 32'd1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle("t4.drain", 1'b1);

        // Back-to-back streaming across pointer wrap.
        for (int i = 0; i < 10; i++) step("t5.stream", 1'b1, 32'(100 + i), 32'(i), 1'b1, 1'b0);
        idle("t5.tail", 1'b1);

        // Overflow set beats a same-cycle clear.
        for (int i = 1; i <= 4; i++) step("t6.fill", 1'b1, 32'(i), 32'd0, 1'b0, 1'b0);
        step("t6.ovfclr", 1'b1, 32'd6, 32'd0, 1'b0, 1'b1);
        step("t6.clr", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle("t6.drain", 1'b1);

        // Asynchronous reset in the middle of operation.
        for (int i = 1; i <= 3; i++) step("t7.fill", 1'b1, 32'(i), 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        mdl_q.delete();
        mdl_ovf = 1'b0;
        check_all("t7.rst");
        #2;
        reset = 1'b0;
        step("t7.push", 1'b1, 32'd7, 32'd0, 1'b0, 1'b0);
        idle("t7.pop", 1'b1);
        idle("t7.empty", 1'b1);

        // Random traffic, including head stability while o_ready toggles.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rr;
            rr = ($urandom_range(0, 7) == 0) ? ONES : $urandom();
            step("rand", 1'($urandom_range(0, 1)), $urandom(), rr,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
